sqrt_sum_pipe_aware_fsm: RTL and testbench

Parametrised FSM-plus-datapath that computes res = isqrt(x0) + isqrt(x1) + … + isqrt(xN-1) for N arguments captured in a single transaction. It drives one shared pipelined isqrt instance through ports; the isqrt is instantiated beside it in a top-level wrapper. Versus the fixed three-argument formula FSM it adds:

- generic argument count and width;
- a ready/valid input handshake;
- response counting, so correct operation does not depend on a fixed isqrt latency.

---
 rtl/sqrt_sum_pipe_aware_fsm.sv | 134 +++++++++++++
 tb/tb_sqrt_sum_pipe_aware_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sum_pipe_aware_fsm.sv
// Sums isqrt() of N latched arguments using one external pipelined isqrt unit.
// Completion is decided by counting returned results, so any isqrt latency >= 1 works.
module sqrt_sum_pipe_aware_fsm #(
    parameter int N     = 3,
    parameter int W     = 32,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    output logic             arg_rdy,
    input  logic [N*W-1:0]   args,
    output logic             res_vld,
    output logic [RES_W-1:0] res,
    output logic             isqrt_x_vld,
    output logic [W-1:0]     isqrt_x,
    input  logic             isqrt_y_vld,
    input  logic [W/2-1:0]   isqrt_y
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_args [N];
    logic [CW-1:0]    r_send_cnt;
    logic [CW-1:0]    r_recv_cnt;
    logic [RES_W-1:0] r_acc;
    logic [RES_W-1:0] r_res;
    logic             r_res_vld;

    logic             w_accept;
    logic             w_collect;
    logic             w_last;
    logic [RES_W-1:0] w_y_ext;
    logic [RES_W-1:0] w_sum;

    assign res     = r_res;
    assign res_vld = r_res_vld;

    // Results are only meaningful while a transaction is in flight
    assign w_collect = isqrt_y_vld && (r_state != S_IDLE);
    assign w_last    = w_collect && (r_recv_cnt == CW'(N - 1));
    assign w_y_ext   = RES_W'(isqrt_y);
    assign w_sum     = r_acc + w_y_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arg_rdy     = 1'b0;
        w_accept    = 1'b0;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;
        case (r_state)
            S_IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                isqrt_x_vld = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (r_send_cnt == CW'(i)) begin
                        isqrt_x = r_args[i];
                    end
                end
                if (r_send_cnt == CW'(N - 1)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_last) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_send_cnt <= '0;
            r_recv_cnt <= '0;
            r_acc      <= '0;
            r_res      <= '0;
            r_res_vld  <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            if (w_accept) begin
                r_send_cnt <= '0;
                r_recv_cnt <= '0;
                r_acc      <= '0;
            end
            if (r_state == S_SEND) begin
                r_send_cnt <= r_send_cnt + CW'(1);
            end
            if (w_collect) begin
                r_acc      <= w_sum;
                r_recv_cnt <= r_recv_cnt + CW'(1);
            end
            if (w_last) begin
                r_res     <= w_sum;
                r_res_vld <= 1'b1;
            end
        end
    end

    // Argument file is pure data: captured on the handshake, never reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_args[i] <= args[i*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_sqrt_sum_pipe_aware_fsm.sv
// Directed bench: three configurations, each driving a latency-L isqrt model.
module tb_sqrt_sum_pipe_aware_fsm;

    localparam int LA = 4;
    localparam int LB = 1;
    localparam int LC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N=3, W=32
    logic         a_vld = 1'b0, a_rdy, a_rv, a_xv, a_yv;
    logic [95:0]  a_args = '0;
    logic [31:0]  a_res, a_x;
    logic [15:0]  a_y;
    logic         inj_v = 1'b0;

    // Instance B: N=1, W=16
    logic         b_vld = 1'b0, b_rdy, b_rv, b_xv, b_yv;
    logic [15:0]  b_args = '0;
    logic [15:0]  b_res, b_x;
    logic [7:0]   b_y;

    // Instance C: N=5, W=32
    logic         c_vld = 1'b0, c_rdy, c_rv, c_xv, c_yv;
    logic [159:0] c_args = '0;
    logic [31:0]  c_res, c_x;
    logic [15:0]  c_y;

    sqrt_sum_pipe_aware_fsm #(.N(3), .W(32), .RES_W(32)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(a_vld), .arg_rdy(a_rdy), .args(a_args),
        .res_vld(a_rv), .res(a_res), .isqrt_x_vld(a_xv), .isqrt_x(a_x),
        .isqrt_y_vld(a_yv), .isqrt_y(a_y)
    );

    sqrt_sum_pipe_aware_fsm #(.N(1), .W(16), .RES_W(16)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(b_vld), .arg_rdy(b_rdy), .args(b_args),
        .res_vld(b_rv), .res(b_res), .isqrt_x_vld(b_xv), .isqrt_x(b_x),
        .isqrt_y_vld(b_yv), .isqrt_y(b_y)
    );

    sqrt_sum_pipe_aware_fsm #(.N(5), .W(32), .RES_W(32)) dut_c (
        .clk(clk), .rst(rst), .arg_vld(c_vld), .arg_rdy(c_rdy), .args(c_args),
        .res_vld(c_rv), .res(c_res), .isqrt_x_vld(c_xv), .isqrt_x(c_x),
        .isqrt_y_vld(c_yv), .isqrt_y(c_y)
    );

    function automatic logic [15:0] sq32(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        logic [63:0] tt;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t  = r | (16'd1 << b);
            tt = 64'(t);
            if (tt * tt <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // isqrt models: shift registers of depth L, flushed by the shared reset
    logic        av [LA];
    logic [15:0] ad [LA];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LA; i++) av[i] <= 1'b0;
        end else begin
            av[0] <= a_xv;
            ad[0] <= sq32(a_x);
            for (int i = 1; i < LA; i++) begin
                av[i] <= av[i-1];
                ad[i] <= ad[i-1];
            end
        end
    end
    assign a_yv = av[LA-1] | inj_v;
    assign a_y  = inj_v ? 16'd7 : ad[LA-1];

    logic       bv [LB];
    logic [7:0] bd [LB];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LB; i++) bv[i] <= 1'b0;
        end else begin
            bv[0] <= b_xv;
            bd[0] <= 8'(sq32({16'd0, b_x}));
            for (int i = 1; i < LB; i++) begin
                bv[i] <= bv[i-1];
                bd[i] <= bd[i-1];
            end
        end
    end
    assign b_yv = bv[LB-1];
    assign b_y  = bd[LB-1];

    logic        cv [LC];
    logic [15:0] cd [LC];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LC; i++) cv[i] <= 1'b0;
        end else begin
            cv[0] <= c_xv;
            cd[0] <= sq32(c_x);
            for (int i = 1; i < LC; i++) begin
                cv[i] <= cv[i-1];
                cd[i] <= cd[i-1];
            end
        end
    end
    assign c_yv = cv[LC-1];
    assign c_y  = cd[LC-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Full-timing check of one isolated transaction on instance A (L=4)
    task automatic run_a(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] exp, input string tag);
        logic [31:0] xs [3];
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        a_args = {x2, x1, x0};
        a_vld  = 1'b1;
        chk({tag, ".rdy0"}, a_rdy, 1);
        tick();
        a_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk({tag, ".xv"}, a_xv, 1);
            chk({tag, ".x"}, a_x, xs[k]);
            chk({tag, ".rdy_busy"}, a_rdy, 0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".xv_wait"}, a_xv, 0);
            chk({tag, ".rv_early"}, a_rv, 0);
            chk({tag, ".rdy_wait"}, a_rdy, 0);
            tick();
        end
        chk({tag, ".rv"}, a_rv, 1);
        chk({tag, ".res"}, a_res, exp);
        chk({tag, ".rdy_done"}, a_rdy, 1);
        tick();
        chk({tag, ".rv_pulse"}, a_rv, 0);
        chk({tag, ".res_hold"}, a_res, exp);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.a_rdy", a_rdy, 1);
        chk("rst.a_rv", a_rv, 0);
        chk("rst.a_res", a_res, 0);
        chk("rst.a_xv", a_xv, 0);
        chk("rst.a_x", a_x, 0);
        chk("rst.b_rdy", b_rdy, 1);
        chk("rst.c_rdy", c_rdy, 1);
        rst = 1'b0;
        tick();

        // Basic transaction and timing
        run_a(32'd16, 32'd25, 32'd36, 32'd15, "t1");
        // Maximum operands and floor behaviour
        run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd196605, "t2max");
        run_a(32'd0, 32'd1, 32'd2, 32'd2, "t2floor");

        // Back-to-back with arg_vld held high and args changed while busy
        a_args = {32'd16, 32'd9, 32'd4};
        a_vld  = 1'b1;
        chk("t3.rdy0", a_rdy, 1);
        tick();
        a_args = {32'd100, 32'd100, 32'd100};
        chk("t3.x1", a_x, 4);
        tick();
        chk("t3.x2", a_x, 9);
        tick();
        chk("t3.x3", a_x, 16);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t3.xv_busy", a_xv, 0);
            chk("t3.rv_early", a_rv, 0);
            tick();
        end
        chk("t3.rv8", a_rv, 1);
        chk("t3.res8", a_res, 9);
        chk("t3.rdy8", a_rdy, 1);
        tick();
        a_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3.xv2", a_xv, 1);
            chk("t3.x2set", a_x, 100);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("t3.rv_early2", a_rv, 0);
            tick();
        end
        chk("t3.rv16", a_rv, 1);
        chk("t3.res16", a_res, 30);
        tick();

        // N=1, W=16, L=1
        b_args = 16'hFFFF;
        b_vld  = 1'b1;
        chk("t4b.rdy0", b_rdy, 1);
        tick();
        b_vld = 1'b0;
        chk("t4b.xv1", b_xv, 1);
        chk("t4b.x1", b_x, 16'hFFFF);
        tick();
        chk("t4b.xv2", b_xv, 0);
        chk("t4b.rv2", b_rv, 0);
        tick();
        chk("t4b.rv3", b_rv, 1);
        chk("t4b.res3", b_res, 255);
        tick();

        // N=5, L=2: results return while still issuing
        c_args = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        c_vld  = 1'b1;
        tick();
        c_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4c.xv", c_xv, 1);
            chk("t4c.x", c_x, 64'((k + 1) * (k + 1)));
            tick();
        end
        chk("t4c.xv6", c_xv, 0);
        chk("t4c.rv6", c_rv, 0);
        tick();
        chk("t4c.rv7", c_rv, 0);
        tick();
        chk("t4c.rv8", c_rv, 1);
        chk("t4c.res8", c_res, 15);
        tick();

        // Mid-transaction reset
        a_args = {32'd36, 32'd25, 32'd16};
        a_vld  = 1'b1;
        tick();
        a_vld = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5.rdy", a_rdy, 1);
        chk("t5.rv", a_rv, 0);
        chk("t5.res", a_res, 0);
        chk("t5.xv", a_xv, 0);
        chk("t5.x", a_x, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t5.no_rv", a_rv, 0);
            chk("t5.idle_xv", a_xv, 0);
            tick();
        end
        run_a(32'd49, 32'd64, 32'd81, 32'd24, "t5next");

        // Spurious isqrt results while idle
        inj_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6.res", a_res, 24);
            chk("t6.rv", a_rv, 0);
            chk("t6.rdy", a_rdy, 1);
        end
        inj_v = 1'b0;
        tick();
        chk("t6.rv_after", a_rv, 0);
        chk("t6.res_after", a_res, 24);
        run_a(32'd16, 32'd25, 32'd36, 32'd15, "t6next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
